// File: rtl/rptr_level_pkg.sv
// Shared definitions for the read-side pointer/level block of the async FIFO.
// Holds the default pointer width and the binary-to-Gray helper that both
// FIFO domains use when publishing their pointers.
package rptr_level_pkg;

  // Default memory address width. Pointers carry one extra wrap bit.
  localparam int DEF_ADDRSIZE = 4;
  localparam int PTRW         = DEF_ADDRSIZE + 1;

  // Working width of the helper function. Callers zero-extend into it and
  // size-cast the result back to their own pointer width.
  localparam int MAXW = 32;
  typedef logic [MAXW-1:0] wide_t;

  // Pointer width for an arbitrary address width, for parametrised users.
  function automatic int ptrw_of(input int addrsize);
    return addrsize + 1;
  endfunction

  // Reflected binary Gray code: neighbouring values differ in one bit, so a
  // pointer can be sampled safely by a 2-flop synchronizer in the other domain.
  function automatic wide_t bin2gray(input wide_t bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/rptr_level_if.sv
// Read-side bus of the async FIFO: pop request, synchronized write pointer,
// threshold programming, underflow clear, and the status/pointer outputs.
// master = FIFO read client, slave = rptr_level.
interface rptr_level_if #(
  parameter int ADDRSIZE = 4
);

  localparam int PW = ADDRSIZE + 1;

  // Requests and configuration from the read client
  logic          rinc;
  logic [PW-1:0] rq2_wptr;
  logic          rarempty_ld;
  logic [PW-1:0] rarempty_th;
  logic          runderflow_clr;

  // Status and pointers produced by the read-side block
  logic                rempty;
  logic                arempty;
  logic [PW-1:0]       rlevel;
  logic [ADDRSIZE-1:0] raddr;
  logic [PW-1:0]       rptr;
  logic                runderflow;

  modport master (
    output rinc, rq2_wptr, rarempty_ld, rarempty_th, runderflow_clr,
    input  rempty, arempty, rlevel, raddr, rptr, runderflow
  );

  modport slave (
    input  rinc, rq2_wptr, rarempty_ld, rarempty_th, runderflow_clr,
    output rempty, arempty, rlevel, raddr, rptr, runderflow
  );

endinterface

// File: rtl/rptr_level_gray2bin.sv
// Gray-to-binary converter of parametrised width. Purely combinational:
// each binary bit is the XOR of all Gray bits at or above its position.
// Shared with the write-side level block.
module rptr_level_gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/rptr_level.sv
// Read-side pointer and status block of the async FIFO (read clock domain).
// Keeps the binary and Gray read pointers, a registered fill level derived
// from the synchronized write pointer, a programmable almost-empty flag and,
// when RPTR_UNDERFLOW_EN is defined, a sticky pop-while-empty flag. Without
// that macro runderflow is tied low and runderflow_clr is ignored; the port
// list is the same in both builds.
module rptr_level
  import rptr_level_pkg::*;
#(
  parameter int ADDRSIZE    = 4,
  parameter int AREMPTYSIZE = 1
) (
  input logic         rclk,
  input logic         rrst,
  rptr_level_if.slave bus
);

  localparam int PW = ptrw_of(ADDRSIZE);

  // Threshold value restored by reset
  localparam logic [PW-1:0] THR_RST = PW'(AREMPTYSIZE);

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] wbin;
  logic [PW-1:0] level_next;
  logic [PW-1:0] rlevel_q;
  logic [PW-1:0] thr;
  logic [PW-1:0] thr_eff;
  logic          rpop;
  logic          rempty_q;
  logic          arempty_q;
  logic          runderflow_q;

  // A pop only happens when the FIFO is known to hold data; rinc while empty
  // is dropped so the pointer can never pass the write pointer.
  assign rpop      = bus.rinc & ~rempty_q;
  assign rbinnext  = rbin + PW'(rpop);
  assign rgraynext = PW'(bin2gray(wide_t'(rbinnext)));

  rptr_level_gray2bin #(
    .WIDTH (PW)
  ) u_wptr_g2b (
    .gray (bus.rq2_wptr),
    .bin  (wbin)
  );

  // Occupancy after this cycle's pop, using the already-synchronized write
  // pointer. Modulo arithmetic makes pointer wrap transparent.
  assign level_next = wbin - rbinnext;

  // A threshold loaded this cycle is compared against straight away.
  assign thr_eff = bus.rarempty_ld ? bus.rarempty_th : thr;

  // Pointer, level, empty/almost-empty flags and threshold register
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin      <= '0;
      rptr_q    <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      arempty_q <= 1'b1;
      thr       <= THR_RST;
    end else begin
      rbin      <= rbinnext;
      rptr_q    <= rgraynext;
      rlevel_q  <= level_next;
      rempty_q  <= (rgraynext == bus.rq2_wptr);
      arempty_q <= (level_next <= thr_eff);
      if (bus.rarempty_ld) begin
        thr <= bus.rarempty_th;
      end
    end
  end

`ifdef RPTR_UNDERFLOW_EN
  // Sticky underflow: any pop attempt while empty sets it; setting beats clearing
  always_ff @(posedge rclk) begin
    if (rrst) begin
      runderflow_q <= 1'b0;
    end else if (bus.rinc & rempty_q) begin
      runderflow_q <= 1'b1;
    end else if (bus.runderflow_clr) begin
      runderflow_q <= 1'b0;
    end
  end
`else
  logic unused_clr;
  assign unused_clr   = bus.runderflow_clr;
  assign runderflow_q = 1'b0;
`endif

  assign bus.rempty     = rempty_q;
  assign bus.arempty    = arempty_q;
  assign bus.rlevel     = rlevel_q;
  assign bus.raddr      = rbin[ADDRSIZE-1:0];
  assign bus.rptr       = rptr_q;
  assign bus.runderflow = runderflow_q;

endmodule
